// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding and digit width for the lock and display FSMs
package lock_pkg;

  localparam int DIGIT_WIDTH = 4;

  localparam logic [1:0] STATE_UNLOCKED = 2'd0;
  localparam logic [1:0] STATE_LOCKED   = 2'd1;
  localparam logic [1:0] STATE_ERROR    = 2'd2;

endpackage

// File: rtl/error_timer.sv
// rtl/error_timer.sv - one-shot down-counter that flags the last cycle of the error window
module error_timer #(
  parameter int ERROR_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic done
);

  localparam int CW = (ERROR_CYCLES > 1) ? $clog2(ERROR_CYCLES) : 1;
  // Loaded with N-1 so done lands on the last of the N error cycles.
  localparam logic [CW-1:0] LOAD = CW'(ERROR_CYCLES - 1);

  logic [CW-1:0] r_count;
  logic          r_active;

  // Load on start, count down while active, drop out once the final cycle is reached.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_count  <= LOAD;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_count == '0) begin
        r_active <= 1'b0;
      end else begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign done = r_active && (r_count == '0);

endmodule

// File: rtl/passcode_lock_fsm.sv
// rtl/passcode_lock_fsm.sv - digit collection, passcode arm/check and error hold for the lock
module passcode_lock_fsm
  import lock_pkg::*;
#(
  parameter int PASSCODE_LENGTH = 4,
  parameter int PASSCODE_WIDTH  = 4 * PASSCODE_LENGTH,
  parameter int ERROR_CYCLES    = 50_000_000,
  parameter int MAX_FAILS       = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DIGIT_WIDTH-1:0]    key,
  input  logic                      digitStrobe,
  input  logic                      enterStrobe,
  output logic                      locked,
  output logic                      error,
  output logic [PASSCODE_WIDTH-1:0] userEntry,
  output logic [1:0]                failCount
);

  localparam int              CNTW   = $clog2(PASSCODE_LENGTH + 1);
  localparam logic [CNTW-1:0] FULL   = CNTW'(PASSCODE_LENGTH);
  localparam logic [1:0]      MAX_F  = 2'(MAX_FAILS);

  logic [1:0]                r_state;
  logic [PASSCODE_WIDTH-1:0] r_entry;
  logic [CNTW-1:0]           r_count;
  logic [PASSCODE_WIDTH-1:0] r_passcode;
  logic                      r_return_locked;
  logic [1:0]                r_fail;
  logic                      r_locked;
  logic                      r_error;

  logic [1:0]                w_state_next;
  logic [PASSCODE_WIDTH-1:0] w_entry_next;
  logic [CNTW-1:0]           w_count_next;
  logic [PASSCODE_WIDTH-1:0] w_passcode_next;
  logic                      w_return_next;
  logic [1:0]                w_fail_next;
  logic                      w_locked_next;
  logic                      w_error_next;
  logic                      w_entry_full;
  logic                      w_match;
  logic [PASSCODE_WIDTH-1:0] w_shifted;
  logic                      w_start;
  logic                      w_done;

  assign w_entry_full = (r_count == FULL);
  assign w_match      = w_entry_full && (r_entry == r_passcode);
  // Oldest digit falls off the top; newest lands in the low nibble.
  assign w_shifted    = PASSCODE_WIDTH'({r_entry, key});
  // Timer is kicked only on the transition into ERROR, never while already there.
  assign w_start      = (r_state != STATE_ERROR) && (w_state_next == STATE_ERROR);

  error_timer #(
    .ERROR_CYCLES(ERROR_CYCLES)
  ) u_error_timer (
    .clock(clock),
    .reset(reset),
    .start(w_start),
    .done (w_done)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= STATE_UNLOCKED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the entry/passcode/failure bookkeeping that goes with each transition.
  always_comb begin
    w_state_next    = r_state;
    w_entry_next    = r_entry;
    w_count_next    = r_count;
    w_passcode_next = r_passcode;
    w_return_next   = r_return_locked;
    w_fail_next     = r_fail;
    case (r_state)
      STATE_UNLOCKED: begin
        if (enterStrobe) begin
          w_entry_next = '0;
          w_count_next = '0;
          if (w_entry_full) begin
            w_passcode_next = r_entry;
            w_state_next    = STATE_LOCKED;
          end else begin
            w_return_next = 1'b0;
            w_state_next  = STATE_ERROR;
          end
        end else if (digitStrobe && !w_entry_full) begin
          w_entry_next = w_shifted;
          w_count_next = r_count + CNTW'(1);
        end
      end
      STATE_LOCKED: begin
        if (enterStrobe) begin
          w_entry_next = '0;
          w_count_next = '0;
          if (w_match) begin
            w_fail_next  = '0;
            w_state_next = STATE_UNLOCKED;
          end else begin
            if (r_fail < MAX_F) begin
              w_fail_next = r_fail + 2'd1;
            end
            w_return_next = 1'b1;
            w_state_next  = STATE_ERROR;
          end
        end else if (digitStrobe && !w_entry_full) begin
          w_entry_next = w_shifted;
          w_count_next = r_count + CNTW'(1);
        end
      end
      STATE_ERROR: begin
        if (w_done) begin
          w_state_next = r_return_locked ? STATE_LOCKED : STATE_UNLOCKED;
        end
      end
      default: begin
        w_state_next = STATE_UNLOCKED;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with the state change.
  always_comb begin
    w_locked_next = 1'b0;
    w_error_next  = 1'b0;
    case (w_state_next)
      STATE_LOCKED: w_locked_next = 1'b1;
      STATE_ERROR: begin
        w_locked_next = w_return_next;
        w_error_next  = 1'b1;
      end
      default: w_locked_next = 1'b0;
    endcase
  end

  // Datapath registers: entry buffer, stored passcode, return target and failure count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_entry         <= '0;
      r_count         <= '0;
      r_passcode      <= '0;
      r_return_locked <= 1'b0;
      r_fail          <= '0;
    end else begin
      r_entry         <= w_entry_next;
      r_count         <= w_count_next;
      r_passcode      <= w_passcode_next;
      r_return_locked <= w_return_next;
      r_fail          <= w_fail_next;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_locked <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_locked <= w_locked_next;
      r_error  <= w_error_next;
    end
  end

  assign locked    = r_locked;
  assign error     = r_error;
  assign userEntry = r_entry;
  assign failCount = r_fail;

endmodule
